// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_pkg
// Description : Shared constants, types and helpers for the 8-to-3 priority
//               encoder (request vector and index types, bit reversal).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Mirror a request vector (bit 0 <-> bit 7). Lets the upward-searching
  // selector implement "highest index wins" with a constant base of 0.
  function automatic req_vec_t reverse_bits(input req_vec_t v);
    req_vec_t r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r[i] = v[NUM_REQ-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_select8.sv
`default_nettype none
// ============================================================================
// Module      : prio_select8
// Description : Purely combinational circular selector. Searches the request
//               vector upward starting at index base, wrapping 7->0, and
//               reports the first set bit.
// Ports       : p    - request vector to search
//               base - index searched first (highest priority)
//               idx  - index of the first set bit found (0 when none)
//               any  - at least one bit of p is set
// Revision    : 1.0 - initial release
// ============================================================================
import prio_enc_pkg::*;

module prio_select8 (
  input  req_vec_t p,
  input  idx_t     base,
  output idx_t     idx,
  output logic     any
);

  idx_t pos;

  // Walk from the farthest offset back toward base so the closest hit
  // (smallest offset from base) is the last assignment and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = idx_t'(base + idx_t'(i));
      if (p[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prio_encoder8to3.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder8to3
// Description : Registered 8-to-3 priority encoder with a pending-request set
//               and a valid/ready output handshake. Default grant policy is
//               fixed priority (bit 7 highest). Defining PRIO_ENC_RR_EN
//               switches to round-robin priority after the last grant.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset
//               en      - capture enable for in
//               in      - request lines
//               ready   - consumer accepts out this cycle
//               out     - registered granted index
//               valid   - out holds a granted index
//               pending - captured, not-yet-accepted requests
// Macro       : PRIO_ENC_RR_EN - enable round-robin grant policy
// Revision    : 1.0 - initial release
// ============================================================================
import prio_enc_pkg::*;

module prio_encoder8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       ready,
  output logic [2:0] out,
  output logic       valid,
  output logic [7:0] pending
);

  logic     transfer;
  req_vec_t clr;
  req_vec_t elig;
  req_vec_t sel_p;
  idx_t     sel_base;
  idx_t     sel_idx;
  idx_t     next_idx;
  logic     sel_any;

  assign transfer = valid & ready;
  assign clr      = transfer ? (req_vec_t'(1) << out) : '0;
  // Next grant is chosen from the current pending set only; freshly sampled
  // requests become eligible one cycle later.
  assign elig     = pending & ~clr;

`ifdef PRIO_ENC_RR_EN
  idx_t last;

  assign sel_p    = elig;
  assign sel_base = idx_t'(last + 3'd1);
  assign next_idx = sel_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 3'd7;
    end else if (transfer) begin
      last <= out;
    end
  end
`else
  // Mirrored vector searched from 0 means original bit 7 is tried first;
  // the found index is mirrored back (7 - i == ~i for 3 bits).
  assign sel_p    = reverse_bits(elig);
  assign sel_base = '0;
  assign next_idx = ~sel_idx;
`endif

  prio_select8 u_select (
    .p    (sel_p),
    .base (sel_base),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      out     <= '0;
      valid   <= 1'b0;
    end else begin
      // A re-assertion on the clearing edge keeps the bit pending.
      pending <= elig | (en ? in : 8'h00);
      if (!valid || transfer) begin
        valid <= sel_any;
        out   <= sel_any ? next_idx : 3'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder8to3.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_encoder8to3
// Description : Directed self-checking bench for prio_encoder8to3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic       ready;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pending;

  int total;
  int bad;

  prio_encoder8to3 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in      (in),
    .ready   (ready),
    .out     (out),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h00;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", pending); end
    total++; if (out !== 3'd0)      begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
    total++; if (valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
  endtask

  task automatic test_basic();
    logic [2:0] e1, e2;
`ifdef PRIO_ENC_RR_EN
    e1 = 3'd2; e2 = 3'd5;
`else
    e1 = 3'd5; e2 = 3'd2;
`endif
    do_reset();
    en = 1'b1; in = 8'b0010_0100; ready = 1'b1;
    step();
    en = 1'b0; in = 8'h00;
    total++; if (pending !== 8'h24) begin bad++; $display("FAIL basic_capture got=%h exp=24", pending); end
    total++; if (valid !== 1'b0)    begin bad++; $display("FAIL basic_latency got=%b exp=0", valid); end
    step();
    total++; if (valid !== 1'b1 || out !== e1) begin bad++; $display("FAIL basic_first got=%b/%0d exp=1/%0d", valid, out, e1); end
    step();
    total++; if (valid !== 1'b1 || out !== e2) begin bad++; $display("FAIL basic_second got=%b/%0d exp=1/%0d", valid, out, e2); end
    step();
    total++; if (valid !== 1'b0 || pending !== 8'h00 || out !== 3'd0) begin
      bad++; $display("FAIL basic_drain got=%b/%h/%0d exp=0/00/0", valid, pending, out);
    end
  endtask

  task automatic test_hold();
    logic [2:0] e;
`ifdef PRIO_ENC_RR_EN
    e = 3'd0;
`else
    e = 3'd7;
`endif
    do_reset();
    en = 1'b1; in = 8'hFF; ready = 1'b0;
    step();
    en = 1'b0; in = 8'h00;
    step();
    for (int k = 0; k < 5; k++) begin
      total++; if (valid !== 1'b1 || out !== e || pending !== 8'hFF) begin
        bad++; $display("FAIL hold_stable cyc=%0d got=%b/%0d/%h exp=1/%0d/ff", k, valid, out, pending, e);
      end
      step();
    end
    ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
`ifdef PRIO_ENC_RR_EN
      e = 3'(k);
`else
      e = 3'(7 - k);
`endif
      total++; if (valid !== 1'b1 || out !== e) begin
        bad++; $display("FAIL hold_drain k=%0d got=%b/%0d exp=1/%0d", k, valid, out, e);
      end
    end
    step();
    total++; if (valid !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL hold_empty got=%b/%h exp=0/00", valid, pending);
    end
  endtask

  task automatic test_reassert();
    do_reset();
    en = 1'b1; in = 8'h08; ready = 1'b0;
    step();
    en = 1'b0; in = 8'h00;
    step();
    total++; if (valid !== 1'b1 || out !== 3'd3) begin bad++; $display("FAIL reassert_grant got=%b/%0d exp=1/3", valid, out); end
    // Re-assert bit 3 on the edge where it transfers.
    en = 1'b1; in = 8'h08; ready = 1'b1;
    step();
    en = 1'b0; in = 8'h00;
    total++; if (pending !== 8'h08) begin bad++; $display("FAIL reassert_pending got=%h exp=08", pending); end
    total++; if (valid !== 1'b0)    begin bad++; $display("FAIL reassert_gap got=%b exp=0", valid); end
    step();
    total++; if (valid !== 1'b1 || out !== 3'd3) begin bad++; $display("FAIL reassert_regrant got=%b/%0d exp=1/3", valid, out); end
    step();
    total++; if (valid !== 1'b0 || pending !== 8'h00) begin bad++; $display("FAIL reassert_empty got=%b/%h exp=0/00", valid, pending); end
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b0; in = 8'hFF; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (pending !== 8'h00 || valid !== 1'b0) begin
        bad++; $display("FAIL en_low cyc=%0d got=%h/%b exp=00/0", k, pending, valid);
      end
    end
    in = 8'h00;
  endtask

  task automatic test_async_reset();
    logic [2:0] e;
`ifdef PRIO_ENC_RR_EN
    e = 3'd5;
`else
    e = 3'd7;
`endif
    do_reset();
    en = 1'b1; in = 8'hA0; ready = 1'b0;
    step();
    en = 1'b0; in = 8'h00;
    step();
    total++; if (valid !== 1'b1 || out !== e || pending !== 8'hA0) begin
      bad++; $display("FAIL arst_setup got=%b/%0d/%h exp=1/%0d/a0", valid, out, pending, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pending !== 8'h00 || out !== 3'd0 || valid !== 1'b0) begin
      bad++; $display("FAIL arst_async got=%h/%0d/%b exp=00/0/0", pending, out, valid);
    end
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (valid !== 1'b0 || pending !== 8'h00) begin
        bad++; $display("FAIL arst_no_grant cyc=%0d got=%b/%h exp=0/00", k, valid, pending);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ea, eb, e;
`ifdef PRIO_ENC_RR_EN
    ea = 3'd0; eb = 3'd7;
`else
    ea = 3'd7; eb = 3'd0;
`endif
    do_reset();
    en = 1'b1; in = 8'b1000_0001; ready = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? ea : eb;
      total++; if (valid !== 1'b1 || out !== e) begin
        bad++; $display("FAIL b2b cyc=%0d got=%b/%0d exp=1/%0d", k, valid, out, e);
      end
      step();
    end
    en = 1'b0; in = 8'h00; ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h00;
    ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_reassert();
    test_en_low();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
